serial_sub: RTL
===============

# serial_sub

Bit-serial WIDTH-bit subtractor for the MIPS datapath. It computes a − b − bin one bit per clock, LSB first, using a single-bit full-subtractor cell with the same semantics as the team's 1-bit `sub` cell. A single borrow flip-flop carries the borrow between cycles. The block uses a start/busy/done handshake and lets area-constrained configurations replace a parallel subtract in the ALU/branch-compare path.

## Interface
- WIDTH, 32, operand and result width in bits (WIDTH ≥ 2)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low; 0 forces reset state immediately
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  initial borrow-in; captured when start is accepted
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse while in DONE; results valid from this cycle
- diff  output  WIDTH  registered result (a − b − bin) mod 2^WIDTH
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
- zero  output  1  diff == 0
- ovf  output  1  signed overflow: a[MSB] ≠ b[MSB] and diff[MSB] ≠ a[MSB]

## Operation
- Bit cell: s = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br). Here x and y are the current LSBs of the operand shift registers, and br is the borrow flip-flop.
- FSM states:
  - IDLE: on start=1, load the a/b shift registers and br ← bin, clear the bit counter, and go to RUN.
  - RUN: each cycle computes one bit, shifts s into the MSB of the internal result shift register, shifts both operand registers right by one, updates br, and increments the counter.
  - RUN exit: when the counter reaches WIDTH−1 and its bit is processed, go to DONE.
  - DONE: done=1; go to IDLE next edge unconditionally.
- The transition into DONE loads diff, bout, zero and ovf together from the completed result and final borrow. These outputs hold until the next operation's transition into DONE.
- start is ignored in RUN and DONE; there is no queueing. start held high in IDLE launches a new operation each time IDLE is re-entered.
- Operands are captured at acceptance. Changes to a/b/bin afterwards have no effect.
- Counter width: clog2(WIDTH). No wrap past WIDTH−1 occurs because RUN exits there.
- Reset (rst=0, at any time including mid-RUN):
  - State goes to IDLE and the operation is discarded.
  - busy=0, done=0, diff=0, bout=0, zero=0, ovf=0; internal shift registers, br and counter are cleared.
  - The first start after rst returns to 1 is accepted normally.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 from after E0.
- Edges E1..EWIDTH process bits 0..WIDTH−1.
- After EWIDTH: state=DONE, done=1, new diff/bout/zero/ovf visible.
- After EWIDTH+1: state=IDLE, done=0, busy=0. Busy spans WIDTH+1 cycles.
- Earliest next acceptance is EWIDTH+2. Throughput is one operation per WIDTH+2 cycles with start held high.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0 → after 8 processing edges: done pulse, diff=0x02, bout=0, zero=0, ovf=0. busy high for exactly 9 cycles.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, zero=0, ovf=0; the previous diff=0x02 holds until this done.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, zero=1, bout=0. Also a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Pulse start with new operands during RUN → ignored; the result matches the original operands. Change a/b mid-RUN → no effect.
- Assert rst=0 at processing edge 4 → all outputs 0 and busy=0 immediately, asynchronously. Release, start a=0x09, b=0x04 → diff=0x05 with normal latency.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Start/busy/done handshake; results held in output registers until the next completion.
module serial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_sgn_q, a_sgn_d;
    logic             b_sgn_q, b_sgn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             br_nx;
    logic [WIDTH-1:0] res_nx;

    // Full-subtractor cell on the operand LSBs; res_nx is the result after this bit lands in the MSB
    always_comb begin
        bit_s  = a_q[0] ^ b_q[0] ^ br_q;
        br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_nx = {bit_s, res_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_sgn_d = a_sgn_q;
        b_sgn_d = b_sgn_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_sgn_d = a[WIDTH-1];
                    b_sgn_d = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_nx[WIDTH-1:1];
                br_d  = br_nx;
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish the whole result set at once
                    diff_d  = res_nx;
                    bout_d  = br_nx;
                    zero_d  = (res_nx == '0);
                    ovf_d   = (a_sgn_q ^ b_sgn_q) & (bit_s ^ a_sgn_q);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_sgn_q <= 1'b0;
            b_sgn_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_sgn_q <= a_sgn_d;
            b_sgn_q <= b_sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
